// File: rtl/jam_cost_arb_pkg.sv
// Shared constants and state encoding for the cost-table arbiter.
//   N_REQ    : default number of requesters
//   LOCK_MAX : maximum consecutive grants under one lock
//   IDX_W    : worker/job index width
//   COST_W   : cost table data width
package jam_pkg;
  localparam int N_REQ    = 4;
  localparam int LOCK_MAX = 8;
  localparam int IDX_W    = 3;
  localparam int COST_W   = 7;

  typedef enum logic {
    OPEN   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;
endpackage

// File: rtl/jam_cost_arb_if.sv
// Requester / cost-table bus of jam_cost_arb.
//   req, lock      : per-requester request and burst-hold
//   req_w, req_j   : packed 3-bit worker / job indices, requester i at [3i+2:3i]
//   gnt            : one-hot combinational accept
//   W, J           : registered indices to the cost table
//   Cost           : table data for the current W/J
//   rsp_valid/data : registered one-hot response and its cost
// master = requesters plus table, slave = arbiter.
interface jam_cost_arb_if #(parameter int N_REQ = jam_pkg::N_REQ);
  import jam_pkg::*;

  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       lock;
  logic [IDX_W*N_REQ-1:0] req_w;
  logic [IDX_W*N_REQ-1:0] req_j;
  logic [N_REQ-1:0]       gnt;
  logic [IDX_W-1:0]       W;
  logic [IDX_W-1:0]       J;
  logic [COST_W-1:0]      Cost;
  logic [N_REQ-1:0]       rsp_valid;
  logic [COST_W-1:0]      rsp_data;

  modport master (output req, lock, req_w, req_j, Cost,
                  input  gnt, W, J, rsp_valid, rsp_data);
  modport slave  (input  req, lock, req_w, req_j, Cost,
                  output gnt, W, J, rsp_valid, rsp_data);
endinterface

// File: rtl/jam_cost_arb_rr_pick.sv
// Rotating priority encoder: first set bit of req_i at or after ptr_i,
// wrapping from N-1 to 0.
//   req_i : request vector      ptr_i : search start index
//   gnt_o : one-hot winner      idx_o : winner index      any_o : a winner exists
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);
  logic [PW-1:0] c;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    c     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      c = PW'((32'(ptr_i) + k) % N);
      if (!any_o && req_i[c]) begin
        any_o    = 1'b1;
        idx_o    = c;
        gnt_o[c] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/jam_cost_arb.sv
// Arbiter sharing one cost-table read port among N_REQ requesters.
// Round-robin when OPEN; a grant with lock held keeps the port for up to
// LOCK_MAX consecutive grants. Two-stage pipeline: indices are registered
// the cycle after a transfer, response one cycle later.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : slave side of jam_cost_arb_if
module jam_cost_arb #(
  parameter int N_REQ    = jam_pkg::N_REQ,
  parameter int LOCK_MAX = jam_pkg::LOCK_MAX
) (
  input  logic           CLK,
  input  logic           RST,
  jam_cost_arb_if.slave  bus
);
  import jam_pkg::*;

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e        state_q;
  logic [PW-1:0]     ptr_q;
  logic [PW-1:0]     owner_l_q;
  logic [2:0]        lock_cnt_q;
  logic              issue_q;
  logic [PW-1:0]     owner_q;
  logic [IDX_W-1:0]  W_q, J_q;
  logic [N_REQ-1:0]  rsp_valid_q;
  logic [COST_W-1:0] rsp_data_q;

  logic [N_REQ-1:0]  rr_gnt;
  logic [PW-1:0]     rr_idx;
  logic              rr_any;
  logic              hold;
  logic              gnt_any;
  logic [PW-1:0]     gnt_idx;
  logic [IDX_W-1:0]  sel_w, sel_j;

  rr_pick #(.N(N_REQ), .PW(PW)) u_rr_pick (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx),
    .any_o (rr_any)
  );

  // A lock only holds while its owner keeps both req and lock asserted;
  // otherwise this same cycle falls back to round-robin.
  always_comb begin
    hold    = (state_q == LOCKED) && bus.req[owner_l_q] && bus.lock[owner_l_q];
    gnt_idx = hold ? owner_l_q : rr_idx;
    gnt_any = !RST && (hold || rr_any);
    bus.gnt = '0;
    if (gnt_any) bus.gnt = hold ? (N_REQ'(1) << owner_l_q) : rr_gnt;
    sel_w = '0;
    sel_j = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_idx == PW'(i)) begin
        sel_w = bus.req_w[i*IDX_W +: IDX_W];
        sel_j = bus.req_j[i*IDX_W +: IDX_W];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= OPEN;
      ptr_q       <= '0;
      owner_l_q   <= '0;
      lock_cnt_q  <= '0;
      issue_q     <= 1'b0;
      owner_q     <= '0;
      W_q         <= '0;
      J_q         <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      issue_q     <= gnt_any;
      owner_q     <= gnt_idx;
      W_q         <= gnt_any ? sel_w : '0;
      J_q         <= gnt_any ? sel_j : '0;
      rsp_valid_q <= issue_q ? (N_REQ'(1) << owner_q) : '0;
      if (issue_q) rsp_data_q <= bus.Cost;

      if (gnt_any) begin
        if (hold) begin
          // Counter holds 1..LOCK_MAX-1; the LOCK_MAX-th grant releases the
          // lock instead of storing LOCK_MAX, so 3 bits suffice for 8.
          if (lock_cnt_q == 3'(LOCK_MAX - 1)) begin
            state_q    <= OPEN;
            lock_cnt_q <= '0;
            ptr_q      <= (owner_l_q == PW'(N_REQ - 1)) ? '0 : owner_l_q + 1'b1;
          end else begin
            lock_cnt_q <= lock_cnt_q + 3'd1;
          end
        end else begin
          ptr_q <= (rr_idx == PW'(N_REQ - 1)) ? '0 : rr_idx + 1'b1;
          if (bus.lock[rr_idx]) begin
            state_q    <= LOCKED;
            lock_cnt_q <= 3'd1;
            owner_l_q  <= rr_idx;
          end else begin
            state_q    <= OPEN;
            lock_cnt_q <= '0;
          end
        end
      end else begin
        state_q    <= OPEN;
        lock_cnt_q <= '0;
      end
    end
  end

  assign bus.W         = W_q;
  assign bus.J         = J_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_jam_cost_arb.sv
module tb_jam_cost_arb;
  localparam int N  = 4;
  localparam int LM = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  jam_cost_arb_if #(.N_REQ(N)) bus ();

  jam_cost_arb #(.N_REQ(N), .LOCK_MAX(LM)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  logic [6:0] cost_tab [64];
  always_comb bus.Cost = cost_tab[{bus.W, bus.J}];

  int errors = 0;
  int checks = 0;

  // Reference model: the port's owner and how many grants it has used,
  // the next round-robin start, and the transfer / response pipeline.
  int         m_ptr, m_owner, m_run;
  bit         p1_valid;
  int         p1_owner;
  logic [2:0] p1_w, p1_j;
  logic [2:0] exp_W, exp_J;
  logic [3:0] exp_rv;
  logic [6:0] exp_rd;
  logic [3:0] last_gnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_owner = -1; m_run = 0;
    p1_valid = 0; p1_owner = 0; p1_w = 0; p1_j = 0;
    exp_W = 0; exp_J = 0; exp_rv = 0; exp_rd = 0;
  endtask

  // One clock: compare at the falling edge, advance the model, step past
  // the rising edge so new stimulus lands clear of it.
  task automatic tick();
    int  g;
    bit  held;
    int  c;
    @(negedge CLK);
    last_gnt = bus.gnt;
    if (RST) begin
      chk("gnt_in_reset", bus.gnt, 0);
      model_reset();
    end else begin
      g = -1; held = 0;
      if (m_owner >= 0 && bus.req[m_owner] && bus.lock[m_owner]) begin
        g = m_owner; held = 1;
      end else begin
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (g < 0 && bus.req[c]) g = c;
        end
      end
      chk("gnt", bus.gnt, (g < 0) ? 0 : (1 << g));
      chk("W", bus.W, exp_W);
      chk("J", bus.J, exp_J);
      chk("rsp_valid", bus.rsp_valid, exp_rv);
      chk("rsp_data", bus.rsp_data, exp_rd);

      exp_rv = p1_valid ? 4'(1 << p1_owner) : 4'd0;
      if (p1_valid) exp_rd = cost_tab[{p1_w, p1_j}];
      if (g >= 0) begin
        p1_valid = 1; p1_owner = g;
        p1_w = bus.req_w[3*g +: 3];
        p1_j = bus.req_j[3*g +: 3];
        exp_W = p1_w; exp_J = p1_j;
      end else begin
        p1_valid = 0; exp_W = 0; exp_J = 0;
      end

      if (g >= 0 && held) begin
        m_run++;
        if (m_run == LM) begin
          m_owner = -1;
          m_ptr   = (g + 1) % N;
        end
      end else if (g >= 0) begin
        m_ptr = (g + 1) % N;
        if (bus.lock[g]) begin m_owner = g; m_run = 1; end
        else m_owner = -1;
      end else begin
        m_owner = -1;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1;
    for (int i = 0; i < n; i++) tick();
    RST = 1'b0;
  endtask

  task automatic set_req(input logic [3:0] r, input logic [3:0] l);
    bus.req  = r;
    bus.lock = l;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) cost_tab[i] = 7'($urandom);
    cost_tab[5*8 + 3] = 7'd42;
    model_reset();
    set_req(4'b0000, 4'b0000);
    bus.req_w = '0;
    bus.req_j = '0;

    // Reset state
    do_reset(2);
    tick();
    chk("reset_W", bus.W, 0);
    chk("reset_rsp_valid", bus.rsp_valid, 0);

    // Steady full request, no lock: rotating grants
    set_req(4'b1111, 4'b0000);
    bus.req_w = 12'o7531;
    bus.req_j = 12'o2460;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_seq", last_gnt, 1 << (i % 4));
    end
    set_req(4'b0000, 4'b0000);
    tick(); tick();

    // Single requester 2, Cost(5,3)=42
    do_reset(1);
    set_req(4'b0100, 4'b0000);
    bus.req_w = 12'o0500;
    bus.req_j = 12'o0300;
    tick();
    set_req(4'b0000, 4'b0000);
    chk("single_W", bus.W, 5);
    chk("single_J", bus.J, 3);
    tick();
    chk("single_rsp_valid", bus.rsp_valid, 4'b0100);
    chk("single_rsp_data", bus.rsp_data, 42);
    tick();

    // Lock burst by 0 with 1 waiting: eight grants to 0, then 1
    do_reset(1);
    set_req(4'b0011, 4'b0001);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("lock_burst", last_gnt, (i < LM) ? 1 : 2);
    end

    // Lock dropped after three grants while 3 requests
    do_reset(1);
    set_req(4'b1001, 4'b0001);
    for (int i = 0; i < 3; i++) tick();
    set_req(4'b1001, 4'b0000);
    tick();
    chk("lock_drop_gnt", last_gnt, 4'b1000);
    tick();
    chk("ptr_after_drop", last_gnt, 4'b0001);

    // Reset right after a transfer drops the pipeline
    set_req(4'b0000, 4'b0000);
    tick(); tick();
    set_req(4'b1111, 4'b0000);
    tick();
    set_req(4'b0000, 4'b0000);
    do_reset(1);
    chk("rst_drop_W", bus.W, 0);
    chk("rst_drop_J", bus.J, 0);
    tick(); tick();
    chk("rst_drop_rsp", bus.rsp_valid, 0);
    set_req(4'b1111, 4'b0000);
    tick();
    chk("rst_first_gnt", last_gnt, 4'b0001);

    // Random stress
    for (int n = 0; n < 10000; n++) begin
      bus.req   = 4'($urandom);
      bus.lock  = 4'($urandom) & 4'($urandom);
      bus.req_w = 12'($urandom);
      bus.req_j = 12'($urandom);
      RST = ($urandom_range(0, 999) == 0);
      tick();
    end
    RST = 1'b0;
    set_req(4'b0000, 4'b0000);
    tick(); tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
